// File: rtl/permute_pkg.sv
// ============================================================================
// Module   : permute_pkg
// Brief    : Shared mode encodings, default geometry and lane slicing helper
//            for the permute_pipe lane permutation network.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package permute_pkg;

    localparam logic PERM_GATHER  = 1'b0;
    localparam logic PERM_SCATTER = 1'b1;

    localparam int DEF_N   = 4;
    localparam int DEF_W   = 8;
    localparam int DEF_LAT = 2;

    // Bit offset of lane 'lane' inside a flat vector of 'width'-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/permute_core.sv
// ============================================================================
// Module   : permute_core
// Brief    : Combinational gather/scatter lane permutation for one beat.
//            Collision detection built only with PERMUTE_COLLISION_DET_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module permute_core
    import permute_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int SELW = $clog2(N)
) (
    input  logic            i_mode,
    input  logic [N*W-1:0]  i_data,
    input  logic [N*SELW-1:0] i_sel,
    output logic [N*W-1:0]  o_data,
    output logic [N-1:0]    o_lane_vld,
    output logic            o_collision
);

    always_comb begin
        o_data      = '0;
        o_lane_vld  = '0;
        o_collision = 1'b0;
        if (i_mode == PERM_GATHER) begin
            o_lane_vld = '1;
            for (int i = 0; i < N; i++) begin
                o_data[lane_lo(i, W) +: W] =
                    i_data[lane_lo(int'(i_sel[lane_lo(i, SELW) +: SELW]), W) +: W];
            end
        end else begin
            // Ascending source scan: the last (highest-index) writer wins.
            for (int j = 0; j < N; j++) begin
                for (int i = 0; i < N; i++) begin
                    if (int'(i_sel[lane_lo(i, SELW) +: SELW]) == j) begin
`ifdef PERMUTE_COLLISION_DET_EN
                        if (o_lane_vld[j]) begin
                            o_collision = 1'b1;
                        end
`endif
                        o_data[lane_lo(j, W) +: W] = i_data[lane_lo(i, W) +: W];
                        o_lane_vld[j] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/permute_pipe.sv
// ============================================================================
// Module   : permute_pipe
// Brief    : LAT-stage valid/ready pipeline around permute_core. Collision
//            flag and sticky error exist only with PERMUTE_COLLISION_DET_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module permute_pipe
    import permute_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int SELW = $clog2(N),
    parameter int LAT  = DEF_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [N*W-1:0]    in_data,
    input  logic [N*SELW-1:0] in_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*W-1:0]    out_data,
    output logic [N-1:0]      out_lane_vld,
    output logic              out_collision,
    output logic              err_sticky
);

    logic [N*W-1:0] w_perm_data;
    logic [N-1:0]   w_perm_mask;
    logic           w_perm_coll;
    logic           w_advance;

    logic           r_vld  [LAT];
    logic [N*W-1:0] r_data [LAT];
    logic [N-1:0]   r_mask [LAT];

    permute_core #(
        .N    (N),
        .W    (W),
        .SELW (SELW)
    ) u_core (
        .i_mode      (in_mode),
        .i_data      (in_data),
        .i_sel       (in_sel),
        .o_data      (w_perm_data),
        .o_lane_vld  (w_perm_mask),
        .o_collision (w_perm_coll)
    );

    // Whole pipeline moves in lockstep; bubbles are kept, never squeezed.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                r_vld[s]  <= 1'b0;
                r_data[s] <= '0;
                r_mask[s] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0]  <= in_valid;
            r_data[0] <= w_perm_data;
            r_mask[0] <= w_perm_mask;
            for (int s = 1; s < LAT; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_data[s] <= r_data[s-1];
                r_mask[s] <= r_mask[s-1];
            end
        end
    end

    assign out_valid    = r_vld[LAT-1];
    assign out_data     = r_data[LAT-1];
    assign out_lane_vld = r_mask[LAT-1];

`ifdef PERMUTE_COLLISION_DET_EN
    logic r_coll [LAT];
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                r_coll[s] <= 1'b0;
            end
            r_err <= 1'b0;
        end else begin
            if (w_advance) begin
                r_coll[0] <= w_perm_coll;
                for (int s = 1; s < LAT; s++) begin
                    r_coll[s] <= r_coll[s-1];
                end
            end
            // Latch only once the colliding beat is actually consumed.
            if (out_valid && out_ready && r_coll[LAT-1]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_collision = r_coll[LAT-1];
    assign err_sticky    = r_err;
`else
    // The core builds no collision logic here, so this is a constant 0.
    assign out_collision = w_perm_coll;
    assign err_sticky    = 1'b0;
`endif

endmodule

`default_nettype wire
